sync_fifo_ctrl_16x8: RTL

Pointer/flag controller that sits directly upstream of the 16x8 synchronous dual-port RAM and turns it into a synchronous FIFO. It accepts push/pop requests from the producer and consumer, drives the RAM write and read ports, and tracks occupancy and the full, empty, almost-full and almost-empty flags. It also returns the RAM read data to the consumer with a valid strobe aligned to the RAM's 1-cycle read latency, and records overflow and underflow errors.

---
 rtl/sync_fifo_ctrl_16x8.sv | 91 +++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl_16x8.sv
// Pointer/flag controller that turns a 16x8 synchronous dual-port RAM into a FIFO.
// Drives the RAM ports, tracks occupancy and flags, and aligns read data with a valid strobe.
module sync_fifo_ctrl_16x8 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A push into a full FIFO is still legal when a pop frees the slot in the same cycle;
  // the RAM's read-before-write hands the old word to the consumer.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign ram_wr_enb  = push_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = push_data;
  assign ram_rd_enb  = pop_ok;
  assign ram_rd_addr = rd_ptr;

  // The RAM output register already provides the one cycle of read latency.
  assign pop_data = ram_rd_data;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + ADDR_WIDTH'(push_ok);
      rd_ptr    <= rd_ptr + ADDR_WIDTH'(pop_ok);
      pop_valid <= pop_ok;

      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set has priority over clear so a rejection in the clearing cycle is not lost.
      if (push & ~push_ok)  overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;

      if (pop & ~pop_ok)    underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

endmodule
